// File: rtl/sa_col_stream_pkg.sv
// Shared defaults and accumulate helpers for the systolic column.
// Saturating helpers work on 64-bit sign/zero-extended operands, so ACC_W must be <= 62.
package sa_pkg;
  localparam int ROWS_D   = 16;
  localparam int DATA_W_D = 8;
  localparam int ACC_W_D  = 32;

  function automatic int row_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [63:0] sat_add_s(input logic [63:0] a, input logic [63:0] b,
                                            input int w);
    logic signed [63:0] s, mx, mn;
    s  = $signed(a) + $signed(b);
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    if (s > mx)      return mx;
    else if (s < mn) return mn;
    else             return s;
  endfunction

  function automatic logic [63:0] sat_add_u(input logic [63:0] a, input logic [63:0] b,
                                            input int w);
    logic [63:0] s, mx;
    s  = a + b;
    mx = (64'd1 << w) - 64'd1;
    return (s > mx) ? mx : s;
  endfunction
endpackage

// File: rtl/sa_col_stream_if.sv
// Result stream from the column to the collector (valid/ready).
interface sa_col_stream_if #(parameter int ACC_W = 32, parameter int ROW_W = 4);
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic [ROW_W-1:0] res_row;
  logic             res_last;

  modport master (output res_valid, res_data, res_row, res_last, input res_ready);
  modport slave  (input res_valid, res_data, res_row, res_last, output res_ready);
endinterface

// File: rtl/sa_pe_acc.sv
// One column row: fire/weight/data pipeline registers, MAC accumulator and result hold.
module sa_pe_acc import sa_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SAT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_f,
  input  logic [DATA_W-1:0] i_w,
  input  logic [DATA_W-1:0] i_d,
  input  logic              i_sign,
  input  logic              i_clr,
  output logic              o_fire,
  output logic [DATA_W-1:0] o_w,
  output logic [DATA_W-1:0] o_d,
  output logic [ACC_W-1:0]  o_hold,
  output logic              o_done,
  output logic              o_ovf
);
  logic                       r_fire, r_done;
  logic [DATA_W-1:0]          r_w, r_d;
  logic [ACC_W-1:0]           r_acc, r_hold;
  logic signed [2*DATA_W-1:0] w_ps;
  logic [2*DATA_W-1:0]        w_pu;
  logic [ACC_W-1:0]           w_pext, w_sum;
  logic [63:0]                w_a64, w_b64;
  logic                       w_fin;

  assign w_ps  = $signed({{DATA_W{i_d[DATA_W-1]}}, i_d}) * $signed({{DATA_W{i_w[DATA_W-1]}}, i_w});
  assign w_pu  = {{DATA_W{1'b0}}, i_d} * {{DATA_W{1'b0}}, i_w};
  assign w_fin = !i_f && r_fire;

  always_comb begin
    w_pext = i_sign ? ACC_W'(w_ps) : ACC_W'(w_pu);
    w_a64  = i_sign ? 64'($signed(r_acc))  : 64'(r_acc);
    w_b64  = i_sign ? 64'($signed(w_pext)) : 64'(w_pext);
    w_sum  = r_acc + w_pext;
    if (SAT != 0)
      w_sum = i_sign ? ACC_W'(sat_add_s(w_a64, w_b64, ACC_W)) : ACC_W'(sat_add_u(w_a64, w_b64, ACC_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fire <= 1'b0;
      r_w    <= '0;
      r_d    <= '0;
      r_acc  <= '0;
      r_hold <= '0;
      r_done <= 1'b0;
    end else begin
      r_fire <= i_f;
      r_w    <= i_w;
      r_d    <= i_d;
      if (i_f) r_acc <= r_fire ? w_sum : w_pext;
      if (w_fin) r_hold <= r_acc;
      // A finish in the same cycle as the output read keeps the row pending with its new value.
      if (w_fin)      r_done <= 1'b1;
      else if (i_clr) r_done <= 1'b0;
    end
  end

  assign o_fire = r_fire;
  assign o_w    = r_w;
  assign o_d    = r_d;
  assign o_hold = r_hold;
  assign o_done = r_done;
  assign o_ovf  = w_fin && r_done && !i_clr;
endmodule

// File: rtl/sa_col_stream.sv
// Systolic-array column: ROWS MAC rows plus an in-order valid/ready result drain.
module sa_col_stream import sa_pkg::*; #(
  parameter int ROWS   = ROWS_D,
  parameter int DATA_W = DATA_W_D,
  parameter int ACC_W  = ACC_W_D,
  parameter int SAT    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fire_in,
  input  logic [ROWS*DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0]      weight_in,
  input  logic                   sign_en,
  input  logic                   err_clr,
  output logic                   fire_out,
  output logic [ROWS*DATA_W-1:0] data_out,
  output logic [DATA_W-1:0]      weight_out,
  sa_col_stream_if.master        res,
  output logic                   busy,
  output logic                   err_ovf
);
  localparam int ROW_W = row_w(ROWS);

  logic [ROWS-1:0]             w_fire_r, w_done, w_ovf, w_clr, w_f;
  logic [ROWS-1:0][DATA_W-1:0] w_wt_r, w_w;
  logic [ROWS-1:0][ACC_W-1:0]  w_hold;
  logic [ROW_W-1:0]            w_sel;
  logic                        w_any, w_load;
  logic                        r_valid, r_err;
  logic [ACC_W-1:0]            r_data;
  logic [ROW_W-1:0]            r_row;

  genvar k;
  generate
    for (k = 0; k < ROWS; k++) begin : g_row
      if (k == 0) begin : g_head
        assign w_f[k] = fire_in;
        assign w_w[k] = weight_in;
      end else begin : g_chain
        assign w_f[k] = w_fire_r[k-1];
        assign w_w[k] = w_wt_r[k-1];
      end
      assign w_clr[k] = w_load && w_any && (w_sel == ROW_W'(k));

      sa_pe_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SAT(SAT)) u_pe (
        .clk    (clk),
        .rst    (rst),
        .i_f    (w_f[k]),
        .i_w    (w_w[k]),
        .i_d    (data_in[k*DATA_W +: DATA_W]),
        .i_sign (sign_en),
        .i_clr  (w_clr[k]),
        .o_fire (w_fire_r[k]),
        .o_w    (w_wt_r[k]),
        .o_d    (data_out[k*DATA_W +: DATA_W]),
        .o_hold (w_hold[k]),
        .o_done (w_done[k]),
        .o_ovf  (w_ovf[k])
      );
    end
  endgenerate

  // Lowest pending row wins so results leave in row order.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (w_done[i]) begin
        w_any = 1'b1;
        w_sel = ROW_W'(i);
      end
    end
  end

  assign w_load = !r_valid || res.res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_row   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= w_any;
        if (w_any) begin
          r_data <= w_hold[w_sel];
          r_row  <= w_sel;
        end
      end
      if (|w_ovf)       r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  assign fire_out      = w_fire_r[0];
  assign weight_out    = w_wt_r[ROWS-1];
  assign res.res_valid = r_valid;
  assign res.res_data  = r_data;
  assign res.res_row   = r_row;
  assign res.res_last  = (r_row == ROW_W'(ROWS - 1));
  assign busy          = (|w_fire_r) || (|w_done) || r_valid;
  assign err_ovf       = r_err;
endmodule

// File: tb/tb_sa_col_stream.sv
// Directed bench: three 4-row columns (32-bit wrap, 16-bit saturate, 16-bit wrap) on shared stimulus.
module tb_sa_col_stream;
  localparam int ROWS = 4;

  typedef struct {
    int          row;
    logic [63:0] data;
    logic        last;
    int          cyc;
  } rec_t;

  logic              clk = 1'b0;
  logic              rst, fire_in, sign_en, err_clr, ready;
  logic [ROWS*8-1:0] data_in;
  logic [7:0]        weight_in;
  logic              fo0, fo1, fo2, b0, b1, b2, e0, e1, e2;
  logic [ROWS*8-1:0] do0, do1, do2;
  logic [7:0]        wo0, wo1, wo2;
  int                cyc = 0;
  int                n_chk = 0, n_pass = 0;
  rec_t              q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sa_col_stream_if #(.ACC_W(32), .ROW_W(2)) rif0 ();
  sa_col_stream_if #(.ACC_W(16), .ROW_W(2)) rif1 ();
  sa_col_stream_if #(.ACC_W(16), .ROW_W(2)) rif2 ();
  assign rif0.res_ready = ready;
  assign rif1.res_ready = ready;
  assign rif2.res_ready = ready;

  sa_col_stream #(.ROWS(ROWS), .DATA_W(8), .ACC_W(32), .SAT(0)) dut0 (
    .clk(clk), .rst(rst), .fire_in(fire_in), .data_in(data_in), .weight_in(weight_in),
    .sign_en(sign_en), .err_clr(err_clr), .fire_out(fo0), .data_out(do0), .weight_out(wo0),
    .res(rif0), .busy(b0), .err_ovf(e0));
  sa_col_stream #(.ROWS(ROWS), .DATA_W(8), .ACC_W(16), .SAT(1)) dut1 (
    .clk(clk), .rst(rst), .fire_in(fire_in), .data_in(data_in), .weight_in(weight_in),
    .sign_en(sign_en), .err_clr(err_clr), .fire_out(fo1), .data_out(do1), .weight_out(wo1),
    .res(rif1), .busy(b1), .err_ovf(e1));
  sa_col_stream #(.ROWS(ROWS), .DATA_W(8), .ACC_W(16), .SAT(0)) dut2 (
    .clk(clk), .rst(rst), .fire_in(fire_in), .data_in(data_in), .weight_in(weight_in),
    .sign_en(sign_en), .err_clr(err_clr), .fire_out(fo2), .data_out(do2), .weight_out(wo2),
    .res(rif2), .busy(b2), .err_ovf(e2));

  // Record every accepted result (values seen just before the accepting edge).
  always @(posedge clk) begin
    if (rif0.res_valid && rif0.res_ready)
      q0.push_back('{int'(rif0.res_row), 64'(rif0.res_data), rif0.res_last, cyc});
    if (rif1.res_valid && rif1.res_ready)
      q1.push_back('{int'(rif1.res_row), 64'(rif1.res_data), rif1.res_last, cyc});
    if (rif2.res_valid && rif2.res_ready)
      q2.push_back('{int'(rif2.res_row), 64'(rif2.res_data), rif2.res_last, cyc});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_data(input logic [7:0] v);
    data_in = {ROWS{v}};
  endtask

  task automatic clear_q();
    q0.delete(); q1.delete(); q2.delete();
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic rec_t qget(input int which, input int i);
    rec_t r;
    r = '{-1, 64'hdead, 1'b0, -1};
    if (i < qsize(which)) begin
      case (which)
        0:       r = q0[i];
        1:       r = q1[i];
        default: r = q2[i];
      endcase
    end
    return r;
  endfunction

  task automatic wait_q(input int which, input int n, input string tag);
    int budget;
    budget = 60;
    while (qsize(which) < n && budget > 0) begin
      tick();
      budget--;
    end
    if (qsize(which) < n) chk({tag, "_timeout"}, 64'(qsize(which)), 64'(n));
  endtask

  task automatic pass(input int len);
    fire_in = 1'b1;
    tick(len);
    fire_in = 1'b0;
  endtask

  initial begin
    int         p, st_bad;
    rec_t       r;
    logic [31:0] hd;
    logic [1:0]  hr;
    logic       fpat[10];
    logic [7:0] wpat[8];
    fpat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    wpat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    rst = 1'b1; fire_in = 1'b0; sign_en = 1'b0; err_clr = 1'b0; ready = 1'b1;
    set_data(8'd200); weight_in = 8'd3;
    tick(2);
    rst = 1'b0;

    // Reset in the middle of a pass
    tick(5);
    pass(3);
    fire_in = 1'b1;
    rst = 1'b1; fire_in = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_fire_out", 64'(fo0), 64'd0);
    chk("rst_data_out", 64'(do0), 64'd0);
    chk("rst_weight_out", 64'(wo0), 64'd0);
    chk("rst_valid", 64'(rif0.res_valid), 64'd0);
    chk("rst_busy", 64'(b0), 64'd0);
    chk("rst_err", 64'(e0), 64'd0);
    clear_q();
    tick(10);
    chk("rst_no_results", 64'(q0.size()), 64'd0);

    // Unsigned accumulate: 4 x 200 x 3
    tick(5);
    clear_q();
    fire_in = 1'b1;
    tick();
    chk("busy_active", 64'(b0), 64'd1);
    tick(3);
    fire_in = 1'b0;
    p = cyc;
    wait_q(0, 4, "uns");
    for (int i = 0; i < 4; i++) begin
      r = qget(0, i);
      chk($sformatf("uns_row%0d", i), 64'(r.row), 64'(i));
      chk($sformatf("uns_data%0d", i), r.data, 64'd2400);
      chk($sformatf("uns_last%0d", i), 64'(r.last), (i == 3) ? 64'd1 : 64'd0);
      chk($sformatf("uns_cyc%0d", i), 64'(r.cyc), 64'(p + 2 + i));
    end
    wait_q(1, 4, "uns16");
    chk("uns16_data0", qget(1, 0).data, 64'd2400);

    // Signed -128 * -128 over 3 cycles: 49152
    tick(4);
    sign_en = 1'b1; set_data(8'h80); weight_in = 8'h80;
    tick(5);
    clear_q();
    pass(3);
    wait_q(0, 4, "s32"); wait_q(1, 4, "sat"); wait_q(2, 4, "wrap");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s32_data%0d", i), qget(0, i).data, 64'd49152);
      chk($sformatf("sat_data%0d", i), qget(1, i).data, 64'h7FFF);
      chk($sformatf("wrap_data%0d", i), qget(2, i).data, 64'hC000);
    end

    // Backpressure: ready low for 10 cycles after the first valid
    tick(4);
    sign_en = 1'b0; set_data(8'd200); weight_in = 8'd3;
    tick(5);
    clear_q();
    pass(4);
    p = 0;
    while (!rif0.res_valid && p < 30) begin
      tick();
      p++;
    end
    chk("bp_first_valid", 64'(rif0.res_valid), 64'd1);
    ready = 1'b0;
    hd = rif0.res_data; hr = rif0.res_row;
    st_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rif0.res_data !== hd || rif0.res_row !== hr || rif0.res_valid !== 1'b1) st_bad++;
    end
    chk("bp_stable", 64'(st_bad), 64'd0);
    chk("bp_held_row", 64'(hr), 64'd0);
    ready = 1'b1;
    wait_q(0, 4, "bp");
    for (int i = 0; i < 4; i++) begin
      r = qget(0, i);
      chk($sformatf("bp_row%0d", i), 64'(r.row), 64'(i));
      chk($sformatf("bp_data%0d", i), r.data, 64'd2400);
    end
    chk("bp_no_ovf", 64'(e0), 64'd0);

    // Overflow: two passes (5 then 7) with nothing drained
    tick(4);
    ready = 1'b0; set_data(8'd5); weight_in = 8'd1;
    tick(5);
    clear_q();
    pass(1);
    tick(8);
    chk("ovf_before", 64'(e0), 64'd0);
    set_data(8'd7);
    tick();
    pass(1);
    tick(8);
    chk("ovf_set", 64'(e0), 64'd1);
    ready = 1'b1;
    wait_q(0, 5, "ovf");
    chk("ovf_r0_row", 64'(qget(0, 0).row), 64'd0);
    chk("ovf_r0_data", qget(0, 0).data, 64'd5);
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("ovf_row_%0d", i), 64'(qget(0, i).row), 64'(i - 1));
      chk($sformatf("ovf_data_%0d", i), qget(0, i).data, 64'd7);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_cleared", 64'(e0), 64'd0);

    // Back-to-back passes with a 1-cycle gap; fire_out follows fire_in by one cycle
    tick(4);
    set_data(8'd200); weight_in = 8'd3;
    tick(5);
    clear_q();
    for (int i = 0; i < 10; i++) begin
      fire_in = fpat[i];
      tick();
      chk($sformatf("fire_out%0d", i), 64'(fo0), 64'(fpat[i]));
    end
    fire_in = 1'b0;
    wait_q(0, 8, "b2b");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_row%0d", i), 64'(qget(0, i).row), 64'(i % 4));
      chk($sformatf("b2b_data%0d", i), qget(0, i).data, 64'd2400);
    end

    // weight_out is weight_in delayed by ROWS cycles
    for (int i = 0; i < 8; i++) begin
      weight_in = wpat[i];
      tick();
      if (i >= ROWS - 1) chk($sformatf("weight_out%0d", i), 64'(wo0), 64'(wpat[i - ROWS + 1]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sa_col_stream.md
Name: sa_col_stream

Overview:
- Parametrised next-generation systolic-array column with ROWS multiply-accumulate stages.
- Weight and fire tokens ripple down the column one stage per cycle; each row's data is registered and forwarded to the next column.
- New over the fixed 16×int8 column: configurable widths, a signed/unsigned mode, optional saturation, and finished row results drained in row order over a valid/ready stream instead of a combinational mux.
- Sits between the array feeder (skewed data/weight/fire) and the result collector.

Parameters:
- ROWS, 16, number of PE stages (≥2).
- DATA_W, 8, data and weight width.
- ACC_W, 32, accumulator/result width; must be ≥ 2*DATA_W.
- SAT, 0, 1 = saturating accumulate, 0 = wrap-around.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- fire_in  in  1  column compute-enable token.
- data_in  in  ROWS*DATA_W  row k at bits [k*DATA_W +: DATA_W].
- weight_in  in  DATA_W  weight entering stage 0.
- sign_en  in  1  1 = signed operands/accumulate, 0 = unsigned.
- err_clr  in  1  clears err_ovf.
- fire_out  out  1  stage-0 fire register, to the next column.
- data_out  out  ROWS*DATA_W  registered data_in, to the next column.
- weight_out  out  DATA_W  last-stage weight register.
- res_valid  out  1  result stream valid.
- res_ready  in  1  result stream ready.
- res_data  out  ACC_W  row result.
- res_row  out  $clog2(ROWS)  row index of res_data.
- res_last  out  1  res_row == ROWS-1.
- busy  out  1  any fire register, done flag or res_valid set.
- err_ovf  out  1  sticky: unread row result overwritten.

Behaviour:
- Reset: all registers, accumulators, hold/done flags and outputs go to 0. Reset mid-pass discards partial and pending results; the row has no memory of prior state.
- Chain: f_in[0]=fire_in, f_in[k]=fire_r[k-1]; likewise w_in[k] from weight_r[k-1].
  - Every cycle: fire_r[k]<=f_in[k], weight_r[k]<=w_in[k], data_r[k]<=data_in slice k.
  - fire_out=fire_r[0]; weight_out=weight_r[ROWS-1].
- Product p[k] = data_in slice k × w_in[k], 2*DATA_W wide. Both operands are signed when sign_en=1 and unsigned otherwise. p[k] is extended to ACC_W by sign or zero extension.
- Accumulate, per row:
  - Start (f_in=1, fire_r=0): acc<=p.
  - Continue (f_in=1, fire_r=1): acc<=acc+p.
  - Idle: acc holds.
- SAT=1 clamps the accumulate to [-2^(ACC_W-1), 2^(ACC_W-1)-1] when signed, and to [0, 2^ACC_W-1] when unsigned. SAT=0 wraps modulo 2^ACC_W.
- Finish (f_in=0, fire_r=1): hold[k]<=acc (including that cycle's final value), done[k]<=1.
  - If done[k] was already 1 and row k is not being loaded to the output that cycle, hold is overwritten and err_ovf<=1.
- Output register:
  - Loads when !res_valid or (res_valid & res_ready).
  - Source is the lowest-index row with done=1 (hold→res_data, index→res_row); that done flag is cleared.
  - If that row finishes in the same cycle, done stays 1, hold takes the new value, and no overflow is flagged.
  - If nothing is done, res_valid<=0.
  - res_data/res_row are stable while res_valid & !res_ready.
- Latency: with fire_in low first in cycle L, row k is visible done in L+1+k, and res_valid for row k appears in L+2+k when res_ready is held high. All ROWS results drain back-to-back, one per cycle.
- Back-to-back passes are legal with a minimum 1-cycle fire_in gap. A new pass may start while earlier results drain.
- err_ovf clears on rst or err_clr; a set in the same cycle as err_clr wins.

Decomposition:
- Package sa_pkg: default ROWS/DATA_W/ACC_W, a row-index width function, and functions sat_add_s and sat_add_u.
- Sub-module sa_pe_acc (one row: fire/weight/data registers, accumulator, hold, done), instantiated ROWS times by generate.
- The top level holds the priority pick, output register and error logic.

Test Plan:
- Reset values: assert rst during an active pass → next cycle all outputs are 0 and busy=0; no res_valid follows.
- Unsigned accumulate: ROWS=4, sign_en=0, data=200 all rows, weight=3, fire high 4 cycles, ready=1 → res_data=2400 for rows 0..3 in consecutive cycles, res_last on row 3.
- Signed accumulate with saturation: SAT=1, ACC_W=16, DATA_W=8, data=-128, weight=-128, fire high 3 cycles → 32767. With SAT=0 → 49152 mod 2^16 read as -16384.
- Backpressure: res_ready=0 for 10 cycles after the first valid → res_data/res_row held, then rows 0..3 drained in order with no loss and err_ovf=0.
- Overflow: hold res_ready=0, run two passes (results 5 then 7) → err_ovf=1, row 0 later reads 7; err_clr → err_ovf=0.
- Back-to-back passes with a 1-cycle gap, ready=1 → two complete in-order result sets; fire_out and weight_out equal fire_in and weight_in delayed by 1 and ROWS cycles respectively.
